// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: executive state encodings, T-state geometry and HLT opcode.
package sap1_pkg;

  localparam int unsigned T_STATES   = 6;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned ADDR_W     = 4;
  localparam logic [OPCODE_W-1:0] HLT_OPCODE = 4'hF;

  localparam int unsigned T1_IDX = 0;
  localparam int unsigned T2_IDX = 1;
  localparam int unsigned T3_IDX = 2;
  localparam int unsigned T4_IDX = 3;
  localparam int unsigned T5_IDX = 4;
  localparam int unsigned T6_IDX = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } exec_state_e;

endpackage

// File: rtl/ring_counter.sv
// One-hot rotator with enable; shared by the executive and the control unit.
module ring_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] ring
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ring <= WIDTH'(1);
    end else if (en) begin
      ring <= {ring[WIDTH-2:0], ring[WIDTH-1]};
    end
  end

endmodule

// File: rtl/exec_controller.sv
// Run/halt/single-step scheduler: owns the T-state ring and the datapath clock enable.
module exec_controller
  import sap1_pkg::*;
#(
  parameter int unsigned         T_STATES   = sap1_pkg::T_STATES,
  parameter logic [OPCODE_W-1:0] HLT_OPCODE = sap1_pkg::HLT_OPCODE,
  parameter int unsigned         CNT_W      = sap1_pkg::CNT_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run_req,
  input  logic                stop_req,
  input  logic                step_req,
  output logic                step_ack,
  input  logic                bp_enable,
  input  logic [ADDR_W-1:0]   bp_addr,
  input  logic [ADDR_W-1:0]   pc,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                cpu_en,
  output logic [T_STATES-1:0] t_state,
  output logic [1:0]          state,
  output logic                bp_hit,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    instr_count
);

  exec_state_e cur_state, nxt_state;
  logic        stop_pending, stop_pending_nxt;
  logic        bp_hit_nxt;
  logic        step_ack_nxt;
  logic        boundary;
  logic        hlt_det;
  logic        bp_match;

  assign cpu_en   = (cur_state == ST_RUN) || (cur_state == ST_STEP);
  assign state    = cur_state;
  assign boundary = cpu_en & t_state[T_STATES-1];
  assign hlt_det  = cpu_en & t_state[T4_IDX] & (opcode == HLT_OPCODE);
  assign bp_match = bp_enable & (pc == bp_addr);

  ring_counter #(
    .WIDTH (T_STATES)
  ) u_ring (
    .clock (clock),
    .reset (reset),
    .en    (cpu_en),
    .ring  (t_state)
  );

  // Next-state and sticky-flag logic; HLT at T4 outranks any boundary stop.
  always_comb begin
    nxt_state        = cur_state;
    stop_pending_nxt = stop_pending;
    bp_hit_nxt       = bp_hit;
    step_ack_nxt     = 1'b0;
    unique case (cur_state)
      ST_IDLE: begin
        if (run_req && !stop_req) begin
          nxt_state = ST_RUN;
        end else if (step_req && !run_req) begin
          nxt_state = ST_STEP;
        end
        if (nxt_state != ST_IDLE) begin
          bp_hit_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          stop_pending_nxt = 1'b1;
        end
        if (hlt_det) begin
          nxt_state = ST_HALT;
        end else if (boundary && (stop_pending || stop_req || bp_match)) begin
          nxt_state        = ST_IDLE;
          stop_pending_nxt = 1'b0;
          if (bp_match) begin
            bp_hit_nxt = 1'b1;
          end
        end
      end
      ST_STEP: begin
        if (hlt_det) begin
          nxt_state = ST_HALT;
        end else if (boundary) begin
          nxt_state    = ST_IDLE;
          step_ack_nxt = 1'b1;
        end
      end
      ST_HALT: begin
        nxt_state = ST_HALT;
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_state    <= ST_IDLE;
      stop_pending <= 1'b0;
      bp_hit       <= 1'b0;
      step_ack     <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      stop_pending <= stop_pending_nxt;
      bp_hit       <= bp_hit_nxt;
      step_ack     <= step_ack_nxt;
    end
  end

  // Cycle counter saturates so long runs stay meaningful; instruction counter wraps.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (cpu_en && (cycle_count != {CNT_W{1'b1}})) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (boundary) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller with a tiny PC/IR model driving pc and opcode.
module tb_exec_controller;

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       run_req   = 1'b0;
  logic       stop_req  = 1'b0;
  logic       step_req  = 1'b0;
  logic       bp_enable = 1'b0;
  logic [3:0] bp_addr   = 4'h0;
  logic [3:0] pc;
  logic [3:0] opcode;
  logic       step_ack;
  logic       cpu_en;
  logic [5:0] t_state;
  logic [1:0] state;
  logic       bp_hit;
  logic [7:0] cycle_count;
  logic [7:0] instr_count;

  logic [3:0] pc_r;
  logic [3:0] op_r;
  logic [3:0] prog [16];

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  exec_controller dut (
    .clock       (clock),
    .reset       (reset),
    .run_req     (run_req),
    .stop_req    (stop_req),
    .step_req    (step_req),
    .step_ack    (step_ack),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .opcode      (opcode),
    .cpu_en      (cpu_en),
    .t_state     (t_state),
    .state       (state),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  // Fetch model: at T2 the IR opcode is loaded and the PC advances.
  always @(posedge clock) begin
    if (!reset) begin
      pc_r <= 4'h0;
      op_r <= 4'h0;
    end else if (cpu_en && t_state[1]) begin
      op_r <= prog[pc_r];
      pc_r <= pc_r + 4'h1;
    end
  end
  assign pc     = pc_r;
  assign opcode = op_r;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    run_req   = 1'b0;
    stop_req  = 1'b0;
    step_req  = 1'b0;
    bp_enable = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim);
    int n = 0;
    while (state !== s && n < lim) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    run_req = 1'b1;
    cyc(3);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", state); end
    total++; if (t_state !== 6'b000001) begin bad++; $display("FAIL reset_tstate: got %b want 000001", t_state); end
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
    total++; if (cycle_count !== 8'd0 || instr_count !== 8'd0) begin bad++;
      $display("FAIL reset_counts: got cyc=%0d ins=%0d want 0/0", cycle_count, instr_count); end
    total++; if (step_ack !== 1'b0 || bp_hit !== 1'b0) begin bad++;
      $display("FAIL reset_flags: got ack=%b bp=%b want 0/0", step_ack, bp_hit); end
    run_req = 1'b0;
    reset   = 1'b1;
    cyc(1);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_release_idle: got %b want 00", state); end
  endtask

  task automatic test_free_run();
    int en = 0;
    do_reset();
    run_req = 1'b1;
    cyc(1);
    run_req = 1'b0;
    for (int i = 0; i < 100 && state !== 2'b11; i++) begin
      if (cpu_en) en++;
      cyc(1);
    end
    total++; if (state !== 2'b11) begin bad++; $display("FAIL run_halt_state: got %b want 11", state); end
    total++; if (instr_count !== 8'd3) begin bad++; $display("FAIL run_halt_instr: got %0d want 3", instr_count); end
    total++; if (cycle_count !== 8'd22) begin bad++; $display("FAIL run_halt_cycles: got %0d want 22", cycle_count); end
    total++; if (en !== 22) begin bad++; $display("FAIL run_halt_en_cycles: got %0d want 22", en); end
    total++; if (cpu_en !== 1'b0 || t_state !== 6'b010000) begin bad++;
      $display("FAIL run_halt_freeze: got en=%b t=%b want 0/010000", cpu_en, t_state); end
    run_req  = 1'b1;
    step_req = 1'b1;
    stop_req = 1'b1;
    cyc(4);
    run_req  = 1'b0;
    step_req = 1'b0;
    stop_req = 1'b0;
    total++; if (state !== 2'b11 || cycle_count !== 8'd22 || instr_count !== 8'd3) begin bad++;
      $display("FAIL halt_absorb: got st=%b cyc=%0d ins=%0d want 11/22/3", state, cycle_count, instr_count); end
  endtask

  task automatic step_window(input int cycles, input int drop_at, output int en, output int acks);
    en   = 0;
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      if (cpu_en) en++;
      if (step_ack) begin
        acks++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL step_ack_unexpected: got ack with ins=%0d want none", instr_count);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (instr_count !== 8'(e) || state !== 2'b00) begin bad++;
            $display("FAIL step_ack_result: got ins=%0d st=%b want %0d/00", instr_count, state, e); end
        end
      end
      step_req = (i == drop_at);
      cyc(1);
    end
    step_req = 1'b0;
  endtask

  task automatic test_step();
    int en;
    int acks;
    do_reset();
    step_req = 1'b1;
    exp_q.push_back(1);
    cyc(1);
    step_req = 1'b0;
    total++; if (state !== 2'b10) begin bad++; $display("FAIL step_enter: got %b want 10", state); end
    step_window(20, 2, en, acks);
    total++; if (en !== 6) begin bad++; $display("FAIL step_en_cycles: got %0d want 6", en); end
    total++; if (acks !== 1) begin bad++; $display("FAIL step_ack_count: got %0d want 1", acks); end
    total++; if (state !== 2'b00 || instr_count !== 8'd1) begin bad++;
      $display("FAIL step_end: got st=%b ins=%0d want 00/1", state, instr_count); end
    step_req = 1'b1;
    exp_q.push_back(2);
    cyc(1);
    step_req = 1'b0;
    step_window(10, -1, en, acks);
    total++; if (acks !== 1 || en !== 6) begin bad++;
      $display("FAIL step_second: got acks=%0d en=%0d want 1/6", acks, en); end
    total++; if (instr_count !== 8'd2 || cycle_count !== 8'd12 || exp_q.size() != 0) begin bad++;
      $display("FAIL step_second_counts: got ins=%0d cyc=%0d q=%0d want 2/12/0", instr_count, cycle_count, exp_q.size()); end
  endtask

  task automatic test_breakpoint();
    do_reset();
    bp_enable = 1'b1;
    bp_addr   = 4'h2;
    run_req   = 1'b1;
    cyc(1);
    run_req = 1'b0;
    wait_state(2'b00, 100);
    total++; if (state !== 2'b00 || pc !== 4'h2) begin bad++;
      $display("FAIL bp_stop: got st=%b pc=%h want 00/2", state, pc); end
    total++; if (bp_hit !== 1'b1 || instr_count !== 8'd2 || t_state !== 6'b000001) begin bad++;
      $display("FAIL bp_flags: got bp=%b ins=%0d t=%b want 1/2/000001", bp_hit, instr_count, t_state); end
    run_req = 1'b1;
    cyc(1);
    run_req = 1'b0;
    total++; if (state !== 2'b01 || bp_hit !== 1'b0) begin bad++;
      $display("FAIL bp_resume: got st=%b bp=%b want 01/0", state, bp_hit); end
    wait_state(2'b11, 100);
    total++; if (state !== 2'b11 || instr_count !== 8'd3 || bp_hit !== 1'b0) begin bad++;
      $display("FAIL bp_resume_halt: got st=%b ins=%0d bp=%b want 11/3/0", state, instr_count, bp_hit); end
    bp_enable = 1'b0;
  endtask

  task automatic test_step_into_halt();
    int en;
    int acks;
    do_reset();
    bp_enable = 1'b1;
    bp_addr   = 4'h3;
    run_req   = 1'b1;
    cyc(1);
    run_req = 1'b0;
    wait_state(2'b00, 100);
    bp_enable = 1'b0;
    total++; if (pc !== 4'h3 || instr_count !== 8'd3 || bp_hit !== 1'b1) begin bad++;
      $display("FAIL sh_setup: got pc=%h ins=%0d bp=%b want 3/3/1", pc, instr_count, bp_hit); end
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    total++; if (bp_hit !== 1'b0) begin bad++; $display("FAIL sh_bp_clear: got %b want 0", bp_hit); end
    step_window(12, -1, en, acks);
    total++; if (state !== 2'b11 || acks !== 0 || en !== 4) begin bad++;
      $display("FAIL sh_halt: got st=%b acks=%0d en=%0d want 11/0/4", state, acks, en); end
    total++; if (t_state !== 6'b010000 || instr_count !== 8'd3 || cycle_count !== 8'd22) begin bad++;
      $display("FAIL sh_state: got t=%b ins=%0d cyc=%0d want 010000/3/22", t_state, instr_count, cycle_count); end
  endtask

  task automatic test_stop();
    do_reset();
    run_req = 1'b1;
    cyc(1);
    run_req = 1'b0;
    cyc(2);
    total++; if (t_state !== 6'b000100) begin bad++; $display("FAIL stop_at_t3: got %b want 000100", t_state); end
    stop_req = 1'b1;
    cyc(1);
    stop_req = 1'b0;
    total++; if (state !== 2'b01) begin bad++; $display("FAIL stop_continue: got %b want 01", state); end
    wait_state(2'b00, 20);
    total++; if (state !== 2'b00 || t_state !== 6'b000001 || instr_count !== 8'd1 || cycle_count !== 8'd6) begin bad++;
      $display("FAIL stop_boundary: got st=%b t=%b ins=%0d cyc=%0d want 00/000001/1/6", state, t_state, instr_count, cycle_count); end
    run_req  = 1'b1;
    stop_req = 1'b1;
    cyc(1);
    stop_req = 1'b0;
    run_req  = 1'b0;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL stop_run_together: got %b want 00", state); end
    run_req = 1'b1;
    cyc(1);
    run_req = 1'b0;
    cyc(8);
    total++; if (state !== 2'b01) begin bad++; $display("FAIL stop_pending_cleared: got %b want 01", state); end
    for (int i = 0; i < 10 && t_state !== 6'b100000; i++) cyc(1);
    stop_req = 1'b1;
    cyc(1);
    stop_req = 1'b0;
    total++; if (state !== 2'b00 || instr_count !== 8'd3) begin bad++;
      $display("FAIL stop_same_boundary: got st=%b ins=%0d want 00/3", state, instr_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_req = 1'b1;
    cyc(1);
    run_req = 1'b0;
    cyc(4);
    total++; if (t_state !== 6'b010000 || state !== 2'b01) begin bad++;
      $display("FAIL rmid_setup: got t=%b st=%b want 010000/01", t_state, state); end
    reset = 1'b0;
    cyc(1);
    total++; if (state !== 2'b00 || t_state !== 6'b000001 || cpu_en !== 1'b0) begin bad++;
      $display("FAIL rmid_state: got st=%b t=%b en=%b want 00/000001/0", state, t_state, cpu_en); end
    total++; if (cycle_count !== 8'd0 || instr_count !== 8'd0 || step_ack !== 1'b0) begin bad++;
      $display("FAIL rmid_counts: got cyc=%0d ins=%0d ack=%b want 0/0/0", cycle_count, instr_count, step_ack); end
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 4'h0;
    prog[0] = 4'h0;
    prog[1] = 4'h1;
    prog[2] = 4'hE;
    prog[3] = 4'hF;
    test_reset();
    test_free_run();
    test_step();
    test_breakpoint();
    test_step_into_halt();
    test_stop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
